// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment scan controller.
//
// Contents:
//   SEG_A..SEG_G, SEG_DP : bit positions inside an 8-bit segment word
//                          (active-high, [7:1] = a..g, [0] = dp)
//   AN_OFF               : anode word with every digit switched off
//   scan_state_t         : scan FSM state encoding (GUARD / SHOW)
//   an_select()          : active-low one-hot anode word for a digit index
//   lead_blank_mask()    : which digits are leading zeros of a 4-digit value
package digit_scan_ctrl_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // GUARD: anodes dark while the segment lines settle on the new digit.
  // SHOW : the selected digit is lit.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Active-low one-hot anode select for digit idx.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Bit k set when digit k and every digit to its left are zero.
  // Digit 0 is never reported, so a value of zero still shows one "0".
  function automatic logic [3:0] lead_blank_mask(input logic [15:0] d);
    logic [3:0] m;
    m[3] = (d[15:12] == 4'h0);
    m[2] = m[3] & (d[11:8] == 4'h0);
    m[1] = m[2] & (d[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_scan_prescaler.sv
// Dwell prescaler for the digit scanner.
//
// Counts 0..DIV-1 and wraps. Exposes:
//   guard_next : the counter value that will be loaded on the next edge is
//                inside the guard window (cnt < GUARD); lets the parent
//                register its anode/state outputs so they line up with cnt
//   tick       : cnt == DIV-1, last cycle of the current dwell
//
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   guard_next : guard flag for the upcoming cycle
//   tick       : dwell-end tick
module scan_prescaler #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic guard_next,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Next count: wrap to zero at the end of each dwell.
  always_comb begin
    cnt_next = cnt + 1'b1;
    if (cnt == LAST) begin
      cnt_next = '0;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign tick       = (cnt == LAST);
  assign guard_next = (cnt_next < GUARD_END);

endmodule

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
//
// Each digit is held for DIV cycles; the first GUARD cycles of every dwell
// keep all anodes off so the previous digit's pattern cannot ghost onto the
// next one. New values are only adopted at frame boundaries (end of digit 3)
// so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   load, value : one-cycle strobe capturing a 16-bit (4 hex digit) value
//   blank_lead  : suppress leading zero digits
//   dp_mask     : per-digit decimal point enables
//   seg_in      : pattern from the external hex decoder fed by nibble
//   nibble      : registered digit code for the external decoder
//   an          : registered active-low one-hot anode selects
//   seg_out     : segment drive (same encoding as seg_in)
//   frame       : one-cycle pulse on the last cycle of each frame
module digit_scan_ctrl
  import digit_scan_ctrl_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lead,
  input  logic [3:0]  dp_mask,
  input  logic [7:0]  seg_in,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic [7:0]  seg_out,
  output logic        frame
);

  if (GUARD < 1 || DIV < GUARD + 2) begin : g_bad_params
    $error("digit_scan_ctrl: need GUARD >= 1 and DIV >= GUARD+2");
  end

  logic        guard_next;
  logic        tick;
  logic        boundary;
  logic [1:0]  idx;
  logic [1:0]  idx_next;
  logic [15:0] disp;
  logic [15:0] disp_next;
  logic [15:0] pend;
  logic        pend_v;
  logic [3:0]  blank_mask;
  logic        blanked;
  logic        unused_seg_dp;

  scan_state_t state_q;
  scan_state_t state_d;

  scan_prescaler #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .guard_next (guard_next),
    .tick       (tick)
  );

  // The decoder's own dp bit is replaced by dp_mask.
  assign unused_seg_dp = seg_in[SEG_DP];

  assign boundary = tick & (idx == 2'd3);
  assign frame    = boundary;
  assign idx_next = tick ? idx + 2'd1 : idx;

  // Buffered value wins over disp only at a boundary; a load on the
  // boundary cycle itself bypasses the buffer.
  always_comb begin
    disp_next = disp;
    if (boundary) begin
      if (load) begin
        disp_next = value;
      end else if (pend_v) begin
        disp_next = pend;
      end
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GUARD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state follows the prescaler's view of the upcoming cycle; seg_out
  // is driven only while a digit is lit and not suppressed.
  always_comb begin
    state_d = state_q;
    seg_out = 8'h00;
    if (guard_next) begin
      state_d = ST_GUARD;
    end else begin
      state_d = ST_SHOW;
    end
    case (state_q)
      ST_SHOW: begin
        if (!blanked) begin
          seg_out = {seg_in[SEG_A:SEG_G], dp_mask[idx]};
        end
      end
      default: begin
        seg_out = 8'h00;
      end
    endcase
  end

  assign blank_mask = lead_blank_mask(disp);
  assign blanked    = blank_lead & blank_mask[idx];

  // Digit index, display/pending registers and registered decoder/anode
  // outputs. nibble and an are computed from next-cycle values so they
  // change on the same edge as idx and the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= 2'd0;
      disp   <= 16'h0000;
      pend   <= 16'h0000;
      pend_v <= 1'b0;
      nibble <= 4'h0;
      an     <= AN_OFF;
    end else begin
      idx    <= idx_next;
      disp   <= disp_next;
      nibble <= disp_next[{idx_next, 2'b00} +: 4];
      an     <= (state_d == ST_GUARD) ? AN_OFF : an_select(idx_next);
      if (boundary) begin
        pend_v <= 1'b0;
      end else if (load) begin
        pend   <= value;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Self-checking bench for digit_scan_ctrl (DIV=8, GUARD=2).
// A behavioural model tracks time since reset, the displayed value and a
// queue of loads waiting for the next frame; expected outputs are derived
// arithmetically from those.
module tb_digit_scan_ctrl;

  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FR    = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lead;
  logic [3:0]  dp_mask;
  logic [7:0]  seg_in;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [7:0]  seg_out;
  logic        frame;
  logic [16:0] outs;

  int          n_cmp = 0;
  int          n_err = 0;
  int          t = 0;
  logic [15:0] m_disp = 16'h0000;
  logic [15:0] pend_q[$];

  always #5 clk = ~clk;

  digit_scan_ctrl #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .blank_lead (blank_lead),
    .dp_mask    (dp_mask),
    .seg_in     (seg_in),
    .nibble     (nibble),
    .an         (an),
    .seg_out    (seg_out),
    .frame      (frame)
  );

  assign outs = {an, nibble, seg_out, frame};

  // Hex-to-7-segment decoder, {a,b,c,d,e,f,g,dp}, dp left 0.
  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'b1111_1100;
      4'h1: return 8'b0110_0000;
      4'h2: return 8'b1101_1010;
      4'h3: return 8'b1111_0010;
      4'h4: return 8'b0110_0110;
      4'h5: return 8'b1011_0110;
      4'h6: return 8'b1011_1110;
      4'h7: return 8'b1110_0000;
      4'h8: return 8'b1111_1110;
      4'h9: return 8'b1111_0110;
      4'hA: return 8'b1110_1110;
      4'hB: return 8'b0011_1110;
      4'hC: return 8'b1001_1100;
      4'hD: return 8'b0111_1010;
      4'hE: return 8'b1001_1110;
      default: return 8'b1000_1110;
    endcase
  endfunction

  // External decoder; its dp bit is forced high so a design that passes it
  // through instead of dp_mask is visible.
  always_comb seg_in = hex7(nibble) | 8'h01;

  // Expected {an, nibble, seg_out, frame} for the current cycle.
  function automatic logic [16:0] exp_outs();
    int cc;
    int k;
    logic [3:0] a;
    logic [3:0] n;
    logic [7:0] s;
    logic [7:0] h;
    cc = t % DIV;
    k  = (t / DIV) % 4;
    n  = 4'(m_disp >> (4 * k));
    h  = hex7(n);
    if (cc < GUARD) begin
      a = 4'hF;
      s = 8'h00;
    end else begin
      a = ~(4'b0001 << k);
      if (blank_lead && k > 0 && (m_disp >> (4 * k)) == 16'h0000) s = 8'h00;
      else s = {h[7:1], dp_mask[k]};
    end
    return {a, n, s, (cc == DIV - 1) && (k == 3)};
  endfunction

  // One clock edge: advance the model using the inputs the DUT samples.
  task automatic advance();
    @(posedge clk);
    if (rst) begin
      t = 0;
      m_disp = 16'h0000;
      pend_q.delete();
    end else begin
      if (t == FR - 1) begin
        if (load) m_disp = value;
        else if (pend_q.size() > 0) m_disp = pend_q[$];
        pend_q.delete();
      end else if (load) begin
        pend_q.push_back(value);
      end
      t = (t + 1) % FR;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b1;
    value = 16'hDEAD;
    advance();
    advance();
    load = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF) begin n_err++; $display("[TB] FAIL reset_an got %b want 1111", an); end
    n_cmp++;
    if (nibble !== 4'h0) begin n_err++; $display("[TB] FAIL reset_nibble got %h want 0", nibble); end
    n_cmp++;
    if (frame !== 1'b0) begin n_err++; $display("[TB] FAIL reset_frame got %b want 0", frame); end
    n_cmp++;
    if (seg_out !== 8'h00) begin n_err++; $display("[TB] FAIL reset_seg got %h want 00", seg_out); end
    advance();
  endtask

  task automatic test_startup();
    int first = -1;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin
        n_err++;
        $display("[TB] FAIL startup_outs t=%0d got %h want %h", t, outs, exp_outs());
      end
      if (c < DIV) begin
        n_cmp++;
        if (an !== ((c < GUARD) ? 4'hF : 4'hE)) begin
          n_err++;
          $display("[TB] FAIL startup_an cycle=%0d got %b want %b", c, an, (c < GUARD) ? 4'hF : 4'hE);
        end
      end
      if (frame === 1'b1 && first < 0) first = c;
      advance();
    end
    n_cmp++;
    if (first != 31) begin n_err++; $display("[TB] FAIL first_frame got cycle %0d want 31", first); end
  endtask

  task automatic test_load_mid_frame();
    logic [3:0] wn[4];
    logic [3:0] wa[4];
    wn = '{4'h4, 4'h3, 4'h2, 4'h1};
    wa = '{4'hE, 4'hD, 4'hB, 4'h7};
    for (int i = 0; i < FR && t != 0; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL midload_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      advance();
    end
    for (int i = 0; i < 2 * FR; i++) begin
      load = (i == DIV + GUARD);
      value = 16'h1234;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL midload_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      if (t % DIV == GUARD) begin
        n_cmp++;
        if (i < FR && nibble !== 4'h0) begin
          n_err++; $display("[TB] FAIL midload_tear t=%0d got %h want 0", t, nibble);
        end else if (i >= FR && (nibble !== wn[t / DIV] || an !== wa[t / DIV])) begin
          n_err++;
          $display("[TB] FAIL midload_seq digit=%0d got %h/%b want %h/%b", t / DIV, nibble, an, wn[t / DIV], wa[t / DIV]);
        end
      end
      advance();
    end
    load = 1'b0;
  endtask

  task automatic test_last_wins();
    logic [15:0] beef = 16'hBEEF;
    logic [3:0]  want;
    for (int i = 0; i < 3 * FR; i++) begin
      int f = i / FR;
      load = 1'b0;
      if (f == 0 && t == DIV + 1) begin load = 1'b1; value = 16'hAAAA; end
      if (f == 0 && t == 3 * DIV) begin load = 1'b1; value = 16'h5555; end
      if (f == 1 && t == FR - 1) begin load = 1'b1; value = 16'hBEEF; end
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL lastwins_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      if (f > 0 && t % DIV == GUARD) begin
        want = (f == 1) ? 4'h5 : 4'(beef >> (4 * (t / DIV)));
        n_cmp++;
        if (nibble !== want) begin n_err++; $display("[TB] FAIL lastwins_nibble f=%0d t=%0d got %h want %h", f, t, nibble, want); end
      end
      advance();
    end
    load = 1'b0;
  endtask

  task automatic test_blanking();
    logic [7:0] want;
    blank_lead = 1'b1;
    dp_mask = 4'b0000;
    for (int i = 0; i < 3 * FR; i++) begin
      int f = i / FR;
      load = 1'b0;
      if (f == 0 && t == 1) begin load = 1'b1; value = 16'h0007; end
      if (f == 1 && t == 5) begin load = 1'b1; value = 16'h0000; end
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL blank_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      if (f > 0 && t % DIV == GUARD + 1) begin
        want = (t / DIV != 0) ? 8'h00 : ((f == 1) ? 8'hE0 : 8'hFC);
        n_cmp++;
        if (seg_out !== want) begin n_err++; $display("[TB] FAIL blank_seg f=%0d digit=%0d got %h want %h", f, t / DIV, seg_out, want); end
      end
      advance();
    end
    load = 1'b0;
    blank_lead = 1'b0;
  endtask

  task automatic test_dp();
    dp_mask = 4'b0100;
    for (int i = 0; i < FR; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL dp_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      n_cmp++;
      if (seg_out[0] !== (an == 4'b1011)) begin
        n_err++; $display("[TB] FAIL dp_bit t=%0d got %b with an=%b", t, seg_out[0], an);
      end
      advance();
    end
    dp_mask = 4'b0000;
  endtask

  task automatic test_random();
    logic [15:0] masks[5];
    masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
    for (int i = 0; i < 8 * FR; i++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom()) & masks[$urandom_range(0, 4)];
      if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom());
      if ($urandom_range(0, 31) == 0) blank_lead = ~blank_lead;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL random_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      advance();
    end
    load = 1'b0;
    blank_lead = 1'b0;
    dp_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    load = 1'b1;
    value = 16'h9876;
    @(negedge clk);
    n_cmp++;
    if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL rstmid_outs t=%0d got %h want %h", t, outs, exp_outs()); end
    advance();
    load = 1'b0;
    for (int i = 0; i < 2 * FR && t != 2 * DIV + GUARD + 1; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL rstmid_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      advance();
    end
    load = 1'b1;
    value = 16'hCAFE;
    @(negedge clk);
    advance();
    load = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL rstmid_outs t=%0d got %h want %h", t, outs, exp_outs()); end
    advance();
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF || nibble !== 4'h0 || frame !== 1'b0 || seg_out !== 8'h00) begin
      n_err++;
      $display("[TB] FAIL rstmid_values got an=%b nib=%h fr=%b seg=%h want 1111/0/0/00", an, nibble, frame, seg_out);
    end
    advance();
    for (int i = 0; i < 2 * FR; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== exp_outs()) begin n_err++; $display("[TB] FAIL rstmid_outs t=%0d got %h want %h", t, outs, exp_outs()); end
      if (t % DIV == GUARD) begin
        n_cmp++;
        if (nibble !== 4'h0) begin n_err++; $display("[TB] FAIL rstmid_discard t=%0d got %h want 0", t, nibble); end
      end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    value = 16'h0000;
    blank_lead = 1'b0;
    dp_mask = 4'b0000;
    test_reset();
    test_startup();
    test_load_mid_frame();
    test_last_wins();
    test_blanking();
    test_dp();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
